// File: rtl/ladner_fischer_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready flow control.
// A register bank follows every LPS prefix levels, plus one output register after the sum XOR.
module ladner_fischer_pipe #(
   parameter int WIDTH = 32,
   parameter int LPS   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V
);

   localparam int LOGW    = $clog2(WIDTH);
   localparam int NLEV    = LOGW + 1;
   localparam int LATENCY = (NLEV + LPS - 1) / LPS + 1;
   localparam int NB      = LATENCY - 1;

   // Handshake: a beat moves on a rising edge when valid && ready; a stalled output
   // (out_valid && !out_ready) freezes every stage, so in_ready = !stall.
   logic stall;

   logic [WIDTH-1:0] bp, bit_p, in_g, in_p;
   logic             c0;

   logic [NB-1:0][WIDTH-1:0] st_g, st_p, st_bp, nx_g, nx_p;
   logic [NB-1:0]            st_c0, st_v;
   logic [WIDTH-1:0]         cg;

   // One prefix level. Levels 1..LOGW build odd-bit groups (pairs, then Sklansky over
   // pairs); level NLEV resolves each even bit from the odd bit just below it.
   function automatic logic [2*WIDTH-1:0] lf_level(input int k,
                                                   input logic [WIDTH-1:0] g,
                                                   input logic [WIDTH-1:0] p);
      logic [WIDTH-1:0] ng, np;
      logic [LOGW-1:0]  ss;
      int               src, j;
      ng = g;
      np = p;
      for (int i = 0; i < WIDTH; i++) begin
         src = -1;
         j   = i / 2;
         if (k == NLEV) begin
            if ((i % 2 == 0) && (i > 0)) src = i - 1;
         end else if (i % 2 == 1) begin
            if (k == 1) src = i - 1;
            else if (((j >> (k - 2)) & 1) == 1)
               src = 2 * (((j >> (k - 2)) << (k - 2)) - 1) + 1;
         end
         ss = LOGW'(src);
         if (src >= 0) begin
            ng[i] = g[i] | (p[i] & g[ss]);
            np[i] = p[i] & p[ss];
         end
      end
      return {ng, np};
   endfunction

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Operand conditioning; the carry-in enters bit 0 through a gray cell.
   always_comb begin
      bp      = B ^ {WIDTH{op[0]}};
      c0      = op[1] ? Cin : op[0];
      bit_p   = A ^ bp;
      in_g    = A & bp;
      in_g[0] = in_g[0] | (bit_p[0] & c0);
      in_p    = bit_p;
   end

   always_comb begin
      logic [WIDTH-1:0] tg, tp;
      nx_g = '0;
      nx_p = '0;
      tg   = in_g;
      tp   = in_p;
      for (int k = 1; k <= LPS; k++)
         if (k <= NLEV) {tg, tp} = lf_level(k, tg, tp);
      nx_g[0] = tg;
      nx_p[0] = tp;
      for (int b = 1; b < NB; b++) begin
         tg = st_g[b-1];
         tp = st_p[b-1];
         for (int k = b * LPS + 1; k <= (b + 1) * LPS; k++)
            if (k <= NLEV) {tg, tp} = lf_level(k, tg, tp);
         nx_g[b] = tg;
         nx_p[b] = tp;
      end
   end

   // Resolved group carries; the P&c0 term is redundant because c0 already sits in g[0].
   assign cg = st_g[NB-1] | (st_p[NB-1] & {WIDTH{st_c0[NB-1]}});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_v      <= '0;
         out_valid <= 1'b0;
         S         <= '0;
         Cout      <= 1'b0;
         V         <= 1'b0;
      end else if (!stall) begin
         st_v[0]  <= in_valid;
         st_bp[0] <= bit_p;
         st_c0[0] <= c0;
         st_g     <= nx_g;
         st_p     <= nx_p;
         for (int b = 1; b < NB; b++) begin
            st_v[b]  <= st_v[b-1];
            st_bp[b] <= st_bp[b-1];
            st_c0[b] <= st_c0[b-1];
         end
         out_valid <= st_v[NB-1];
         S         <= st_bp[NB-1] ^ {cg[WIDTH-2:0], st_c0[NB-1]};
         Cout      <= cg[WIDTH-1];
         V         <= cg[WIDTH-2] ^ cg[WIDTH-1];
      end
   end

endmodule
